coconut_solver: RTL and testbench
=================================

# coconut_solver

Sequential, parametrised solver for the sailors-coconuts-monkey puzzle. For N sailors and a monkey remainder R, it scans a range of candidate pile sizes, one division round per clock. It reports the smallest candidate that survives N night divisions plus the morning division, together with the morning share. This block replaces single-candidate combinational checking: it generalises sailor count, remainder, data width and morning rule, and adds a start/done handshake.

## Interface
- SAILORS, 5, number of sailors N (2..15); also the number of night rounds
- REM, 1, coconuts given to the monkey per round R (0..SAILORS-1)
- WIDTH, 32, width of candidate, pile, result and share
- MORNING_REM, 1, 1: morning division must leave remainder R; 0: morning division must be exact (remainder 0)
- clk  input  1  single clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  one-cycle request, sampled only in IDLE
- first  input  WIDTH  lowest candidate to try, sampled with start
- last  input  WIDTH  highest candidate to try (inclusive), sampled with start
- busy  output  1  high while searching
- done  output  1  one-cycle pulse at end of search
- found  output  1  valid with done and held after; 1 = solution in range
- result  output  WIDTH  solving candidate; held until next start
- share  output  WIDTH  each sailor's morning share for result; held until next start

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - If first>last: go to DONE with found=0.
  - Otherwise: cand<=first, lim<=last, pile<=first, round<=0, go to RUN.
  - found, result and share clear to 0 on every accepted start.
- RUN evaluates one round per cycle on the current pile. Let q=(pile-R)/N. Let req=R for rounds 0..N-1, and req=(MORNING_REM ? R : 0) for round N.
  - Round passes iff pile%N==req and pile>=N+req (every share must be at least 1).
  - Pass, round<N: pile<=pile-R-q, round<=round+1.
  - Pass, round==N: result<=cand, share<=(pile-req)/N, found<=1, go to DONE.
  - Fail, cand==lim: found stays 0, go to DONE.
  - Fail, cand<lim: cand<=cand+1, pile<=cand+1, round<=0, stay in RUN. No idle cycle between candidates.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE. first and last are not re-sampled.
- Arithmetic:
  - Unsigned, WIDTH bits. Division and modulo are by the constant N only.
  - pile never grows, so there is no overflow.
  - cand never increments past lim, so there is no wrap at 2^WIDTH-1.
- Round counter width is clog2(SAILORS+1).

## Timing
- Reset values: busy=0, done=0, found=0, result=0, share=0; state IDLE.
- busy=1 in RUN and DONE; busy=0 in IDLE.
- Start accepted at edge k. A candidate that passes immediately gives done=1 after edge k+N+1, with result and share valid in the same cycle.
- A candidate rejected at round j costs j+1 cycles.
- first>last: done after edge k+1 with found=0.
- Reset asserted mid-search aborts in the same edge. All outputs return to reset values and no done pulse is emitted.
- start held high across DONE into IDLE starts a new search in the first IDLE cycle.

## Test plan
- Default parameters, first=1, last=20000, start -> done with found=1, result=15621, share=1023; busy low on the following cycle.
- MORNING_REM=0, first=1, last=5000 -> found=1, result=3121, share=204.
- Default parameters, first=15621, last=15621 -> done exactly 6 cycles after start edge, result=15621.
- Default parameters, first=1, last=15620 -> done with found=0, result=0, share=0.
- first=10, last=5 -> done one cycle after start with found=0. Separately: start with first=1, last=20000, assert reset after 100 cycles -> busy=0 next cycle and no done pulse. A fresh start afterwards still returns 15621.
- SAILORS=3, REM=1, MORNING_REM=1, first=1, last=200 -> result=79, share=7. Pulsing start during RUN has no effect.

Source files
------------

// File: rtl/coconut_solver_if.sv
// Request/response bundle for coconut_solver: start with a candidate range,
// then status and the solving candidate with its morning share.
interface coconut_solver_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] last;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] share;

  modport master (
    output start, first, last,
    input  busy, done, found, result, share
  );

  modport slave (
    input  start, first, last,
    output busy, done, found, result, share
  );
endinterface

// File: rtl/coconut_solver.sv
// Sailors-coconuts-monkey search: scans candidates first..last, testing one
// division round per clock, and reports the smallest surviving pile.
module coconut_solver #(
  parameter int SAILORS     = 5,
  parameter int REM         = 1,
  parameter int WIDTH       = 32,
  parameter int MORNING_REM = 1
) (
  input logic             clk,
  input logic             reset,
  coconut_solver_if.slave bus
);
  localparam int RW = $clog2(SAILORS + 1);
  localparam logic [WIDTH-1:0] N_W     = WIDTH'(SAILORS);
  localparam logic [WIDTH-1:0] REM_W   = WIDTH'(REM);
  localparam logic [WIDTH-1:0] MREQ_W  = (MORNING_REM != 0) ? WIDTH'(REM) : {WIDTH{1'b0}};
  localparam logic [RW-1:0]    LAST_RD = RW'(SAILORS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cand_r, cand_s, lim_r, lim_s, pile_r, pile_s;
  logic [RW-1:0]    round_r, round_s;
  logic             empty_r, empty_s;
  logic             busy_r, busy_s, done_r, done_s, found_r, found_s;
  logic [WIDTH-1:0] result_r, result_s, share_r, share_s;
  logic [WIDTH-1:0] req_s, q_s;
  logic             pass_s;

  // Round evaluation on the current pile; the morning round may demand an exact split.
  always_comb begin
    req_s  = (round_r == LAST_RD) ? MREQ_W : REM_W;
    q_s    = (pile_r - REM_W) / N_W;
    pass_s = ((pile_r % N_W) == req_s) && (pile_r >= (N_W + req_s));
  end

  // Next-state and datapath updates for the search FSM.
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    lim_s    = lim_r;
    pile_s   = pile_r;
    round_s  = round_r;
    empty_s  = empty_r;
    found_s  = found_r;
    result_s = result_r;
    share_s  = share_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          // An empty range still passes through RUN once so done lands one cycle later.
          cand_s   = bus.first;
          lim_s    = bus.last;
          pile_s   = bus.first;
          round_s  = {RW{1'b0}};
          empty_s  = (bus.first > bus.last);
          found_s  = 1'b0;
          result_s = {WIDTH{1'b0}};
          share_s  = {WIDTH{1'b0}};
          state_s  = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (empty_r) begin
          state_s = DONE;
        end else if (pass_s) begin
          if (round_r == LAST_RD) begin
            result_s = cand_r;
            share_s  = (pile_r - req_s) / N_W;
            found_s  = 1'b1;
            state_s  = DONE;
          end else begin
            pile_s  = pile_r - REM_W - q_s;
            round_s = round_r + {{(RW-1){1'b0}}, 1'b1};
          end
        end else if (cand_r == lim_r) begin
          state_s = DONE;
        end else begin
          cand_s  = cand_r + {{(WIDTH-1){1'b0}}, 1'b1};
          pile_s  = cand_r + {{(WIDTH-1){1'b0}}, 1'b1};
          round_s = {RW{1'b0}};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cand_r   <= {WIDTH{1'b0}};
      lim_r    <= {WIDTH{1'b0}};
      pile_r   <= {WIDTH{1'b0}};
      round_r  <= {RW{1'b0}};
      empty_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      found_r  <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      share_r  <= {WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      cand_r   <= cand_s;
      lim_r    <= lim_s;
      pile_r   <= pile_s;
      round_r  <= round_s;
      empty_r  <= empty_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      found_r  <= found_s;
      result_r <= result_s;
      share_r  <= share_s;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.found  = found_r;
  assign bus.result = result_r;
  assign bus.share  = share_r;
endmodule

// File: tb/tb_coconut_solver.sv
// Self-checking bench for coconut_solver: table-driven searches on three
// parameterisations plus reset-abort, start-during-RUN and held-start sequences.
module tb_coconut_solver;
  localparam int BUDGET = 40000;

  typedef struct {
    int          sel;
    logic [31:0] first;
    logic [31:0] last;
    logic        exp_found;
    logic [31:0] exp_result;
    logic [31:0] exp_share;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  coconut_solver_if #(.WIDTH(32)) bus_def ();
  coconut_solver_if #(.WIDTH(32)) bus_exact ();
  coconut_solver_if #(.WIDTH(32)) bus_three ();

  coconut_solver u_def (.clk(clk), .reset(reset), .bus(bus_def));
  coconut_solver #(.SAILORS(5), .REM(1), .WIDTH(32), .MORNING_REM(0))
    u_exact (.clk(clk), .reset(reset), .bus(bus_exact));
  coconut_solver #(.SAILORS(3), .REM(1), .WIDTH(32), .MORNING_REM(1))
    u_three (.clk(clk), .reset(reset), .bus(bus_three));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic s, input logic [31:0] f, input logic [31:0] l);
    case (sel)
      0: begin bus_def.start = s;   bus_def.first = f;   bus_def.last = l;   end
      1: begin bus_exact.start = s; bus_exact.first = f; bus_exact.last = l; end
      default: begin bus_three.start = s; bus_three.first = f; bus_three.last = l; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic s);
    case (sel)
      0: bus_def.start = s;
      1: bus_exact.start = s;
      default: bus_three.start = s;
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0: return bus_def.done;
      1: return bus_exact.done;
      default: return bus_three.done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0: return bus_def.busy;
      1: return bus_exact.busy;
      default: return bus_three.busy;
    endcase
  endfunction

  function automatic logic found_of(input int sel);
    case (sel)
      0: return bus_def.found;
      1: return bus_exact.found;
      default: return bus_three.found;
    endcase
  endfunction

  function automatic logic [31:0] result_of(input int sel);
    case (sel)
      0: return bus_def.result;
      1: return bus_exact.result;
      default: return bus_three.result;
    endcase
  endfunction

  function automatic logic [31:0] share_of(input int sel);
    case (sel)
      0: return bus_def.share;
      1: return bus_exact.share;
      default: return bus_three.share;
    endcase
  endfunction

  // Drive a one-cycle start; returns just after the accepting edge.
  task automatic launch(input vec_t v);
    @(negedge clk);
    set_in(v.sel, 1'b1, v.first, v.last);
    sb.push_back(v);
    @(posedge clk);
    #1;
    set_start(v.sel, 1'b0);
  endtask

  // Wait for done, pop the scoreboard and compare; optionally check busy drops afterwards.
  task automatic finish(input string name, input bit check_after);
    vec_t e;
    int   lat;
    bit   got;
    got = 1'b0;
    lat = 0;
    e = sb.pop_front();
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (done_of(e.sel)) begin
        lat = n;
        got = 1'b1;
        break;
      end
    end
    check({name, ".done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, ".found"}, 32'(found_of(e.sel)), 32'(e.exp_found));
      check({name, ".result"}, result_of(e.sel), e.exp_result);
      check({name, ".share"}, share_of(e.sel), e.exp_share);
      if (e.exp_lat >= 0) check({name, ".latency"}, 32'(lat), 32'(e.exp_lat));
      if (check_after) begin
        @(posedge clk);
        #1;
        check({name, ".busy_after"}, 32'(busy_of(e.sel)), 32'd0);
        check({name, ".done_after"}, 32'(done_of(e.sel)), 32'd0);
        check({name, ".found_held"}, 32'(found_of(e.sel)), 32'(e.exp_found));
      end
    end
  endtask

  task automatic check_reset_state(input string name, input int sel);
    check({name, ".busy"}, 32'(busy_of(sel)), 32'd0);
    check({name, ".done"}, 32'(done_of(sel)), 32'd0);
    check({name, ".found"}, 32'(found_of(sel)), 32'd0);
    check({name, ".result"}, result_of(sel), 32'd0);
    check({name, ".share"}, share_of(sel), 32'd0);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    vecs[0] = '{0, 32'd1,     32'd20000, 1'b1, 32'd15621, 32'd1023, -1};
    vecs[1] = '{1, 32'd1,     32'd5000,  1'b1, 32'd3121,  32'd204,  -1};
    vecs[2] = '{0, 32'd15621, 32'd15621, 1'b1, 32'd15621, 32'd1023, 6};
    vecs[3] = '{0, 32'd1,     32'd15620, 1'b0, 32'd0,     32'd0,    -1};
    vecs[4] = '{0, 32'd10,    32'd5,     1'b0, 32'd0,     32'd0,    1};
    vecs[5] = '{2, 32'd1,     32'd200,   1'b1, 32'd79,    32'd7,    -1};
    vecs[6] = '{1, 32'd3121,  32'd3121,  1'b1, 32'd3121,  32'd204,  6};
    vecs[7] = '{2, 32'd79,    32'd79,    1'b1, 32'd79,    32'd7,    4};

    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset_def", 0);
    check_reset_state("reset_exact", 1);
    check_reset_state("reset_three", 2);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i]);
      finish($sformatf("vec%0d", i), 1'b1);
    end

    // Reset mid-search aborts silently; a fresh search still finds the answer.
    v = '{0, 32'd1, 32'd20000, 1'b1, 32'd15621, 32'd1023, -1};
    @(negedge clk);
    set_in(0, 1'b1, v.first, v.last);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("abort", 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done_of(0) || busy_of(0)) seen = 1'b1;
    end
    check("abort.no_done", 32'(seen), 32'd0);
    v = '{0, 32'd15000, 32'd20000, 1'b1, 32'd15621, 32'd1023, -1};
    launch(v);
    finish("after_abort", 1'b1);

    // Start pulses during RUN with a different range are ignored.
    v = '{2, 32'd1, 32'd200, 1'b1, 32'd79, 32'd7, -1};
    launch(v);
    repeat (10) @(posedge clk);
    @(negedge clk);
    set_in(2, 1'b1, 32'd100, 32'd100);
    @(negedge clk);
    set_in(2, 1'b0, 32'd1, 32'd200);
    check("run_pulse.busy", 32'(busy_of(2)), 32'd1);
    finish("run_pulse", 1'b1);

    // Start held across DONE is accepted in the first IDLE cycle.
    v = '{2, 32'd79, 32'd79, 1'b1, 32'd79, 32'd7, 4};
    @(negedge clk);
    set_in(2, 1'b1, v.first, v.last);
    sb.push_back(v);
    @(posedge clk);
    #1;
    finish("held1", 1'b0);
    @(posedge clk);
    #1;
    check("held.idle_busy", 32'(busy_of(2)), 32'd0);
    sb.push_back(v);
    @(posedge clk);
    #1;
    set_start(2, 1'b0);
    check("held.accepted_busy", 32'(busy_of(2)), 32'd1);
    check("held.found_cleared", 32'(found_of(2)), 32'd0);
    check("held.result_cleared", result_of(2), 32'd0);
    finish("held2", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
